// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse keyer shared types and timing constants (optional MORSE_TX_WORD_GAP_EN)
package morse_pkg;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MAX_LEN        = 5;

    localparam int PAT_W = 5;
    localparam int LEN_W = 3;

`ifdef MORSE_TX_WORD_GAP_EN
    localparam int UNITS_W = 3;
`else
    localparam int UNITS_W = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_CGAP
`ifdef MORSE_TX_WORD_GAP_EN
        ,
        S_WGAP
`endif
    } state_t;

    function automatic logic [UNITS_W-1:0] elem_units(input logic is_dash);
        return is_dash ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
    endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// rtl/morse_unit_tick.sv - Morse unit prescaler: tick on the terminal count, held at zero by restart
module morse_unit_tick #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart || r_cnt == TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !restart && (r_cnt == TERM);

endmodule

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - Morse keyer: latches a dot/dash pattern and drives timed key_out (optional MORSE_TX_WORD_GAP_EN)
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000,
    parameter int MAX_LEN     = morse_pkg::MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [PAT_W-1:0] sym_pattern,
    input  logic [LEN_W-1:0] sym_len,
    output logic             sym_ready,
    output logic             key_out,
    output logic             busy,
    output logic             char_done
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [UNITS_W-1:0] LAST_UNIT = UNITS_W'(1);

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_idx;
    logic [UNITS_W-1:0] r_units;
    logic               r_key;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    logic w_tick;
    logic w_restart;
    logic w_legal;
    logic w_last;

    // Prescaler sits at zero while idle, so every character starts on a full unit
    assign w_restart = (r_state == S_IDLE);
    assign w_legal   = (sym_len != '0) && (sym_len <= MAX_LEN_L);
    assign w_last    = w_tick && (r_units == LAST_UNIT);

    morse_unit_tick #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_units <= '0;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_tick && !w_last) begin
                r_units <= r_units - 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sym_valid) begin
                        if (w_legal) begin
                            r_pat   <= sym_pattern;
                            r_idx   <= sym_len - 1'b1;
                            r_units <= elem_units(sym_pattern[sym_len - 1'b1]);
                            r_state <= S_MARK;
                            r_key   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
`ifdef MORSE_TX_WORD_GAP_EN
                        end else if (sym_len == '0) begin
                            r_units <= UNITS_W'(WORD_GAP_UNITS);
                            r_state <= S_WGAP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
`endif
                        end else begin
                            // Illegal length: consume it and report completion without keying
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_last) begin
                        r_key <= 1'b0;
                        if (r_idx != '0) begin
                            r_units <= UNITS_W'(ELEM_GAP_UNITS);
                            r_state <= S_SPACE;
                        end else begin
                            r_units <= UNITS_W'(CHAR_GAP_UNITS);
                            r_state <= S_CGAP;
                        end
                    end
                end
                S_SPACE: begin
                    if (w_last) begin
                        r_idx   <= r_idx - 1'b1;
                        r_units <= elem_units(r_pat[r_idx - 1'b1]);
                        r_key   <= 1'b1;
                        r_state <= S_MARK;
                    end
                end
`ifdef MORSE_TX_WORD_GAP_EN
                S_WGAP,
`endif
                S_CGAP: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_key   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign sym_ready = r_ready;
    assign key_out   = r_key;
    assign busy      = r_busy;
    assign char_done = r_done;

endmodule

// File: tb/tb_morse_tx.sv
// tb/tb_morse_tx.sv - Scoreboard bench for morse_tx with UNIT_CYCLES=4
module tb_morse_tx;

    localparam int UC = 4;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic [4:0] sym_pattern;
    logic [2:0] sym_len;
    logic       sym_ready;
    logic       key_out;
    logic       busy;
    logic       char_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic key;
        logic done;
        logic bsy;
    } exp_t;

    exp_t sb[$];

    morse_tx #(
        .UNIT_CYCLES(UC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_pattern(sym_pattern),
        .sym_len    (sym_len),
        .sym_ready  (sym_ready),
        .key_out    (key_out),
        .busy       (busy),
        .char_done  (char_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_n(input logic k, input int n);
        exp_t e;
        e.key = k; e.done = 1'b0; e.bsy = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Reference timeline: one entry per clock cycle after the accepting edge
    task automatic push_char(input logic [4:0] p, input logic [2:0] n);
        exp_t e;
        if (n >= 3'd1 && n <= 3'd5) begin
            for (int i = int'(n) - 1; i >= 0; i--) begin
                push_n(1'b1, (p[i] ? 3 : 1) * UC);
                if (i > 0) push_n(1'b0, UC);
            end
            push_n(1'b0, 3 * UC);
        end
`ifdef MORSE_TX_WORD_GAP_EN
        else if (n == 3'd0) begin
            push_n(1'b0, 7 * UC);
        end
`endif
        e.key = 1'b0; e.done = 1'b1; e.bsy = 1'b0;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (key_out !== e.key) begin
                bad++;
                $display("FAIL %s key_out cyc=%0d got=%0b exp=%0b", name, cyc, key_out, e.key);
            end
            total++;
            if (char_done !== e.done) begin
                bad++;
                $display("FAIL %s char_done cyc=%0d got=%0b exp=%0b", name, cyc, char_done, e.done);
            end
            total++;
            if (busy !== e.bsy) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%0b exp=%0b", name, cyc, busy, e.bsy);
            end
            total++;
            if (sym_ready !== !e.bsy) begin
                bad++;
                $display("FAIL %s sym_ready cyc=%0d got=%0b exp=%0b", name, cyc, sym_ready, !e.bsy);
            end
            if (sb.size() > 0) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic run_char(input logic [4:0] p, input logic [2:0] n, input string name);
        int guard;
        @(negedge clk);
        sym_valid = 1'b1; sym_pattern = p; sym_len = n;
        guard = 0;
        while (!sym_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL %s accept_timeout got=sym_ready_low exp=sym_ready_high", name);
        end
        push_char(p, n);
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0; sym_pattern = ~p; sym_len = n + 3'd1;
        drain(name);
    endtask

    task automatic test_reset;
        rst = 1'b0; sym_valid = 1'b0; sym_pattern = '0; sym_len = '0;
        #12;
        total++;
        if ({key_out, busy, char_done, sym_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset outputs got=%b exp=0001", {key_out, busy, char_done, sym_ready});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++;
        if ({key_out, busy, char_done, sym_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset outputs got=%b exp=0001", {key_out, busy, char_done, sym_ready});
        end
    endtask

    task automatic test_chars;
        run_char(5'b00000, 3'd1, "E");
        run_char(5'b00001, 3'd2, "A");
        run_char(5'b11111, 3'd5, "zero");
        run_char(5'b00110, 3'd4, "mixed");
        run_char(5'b00001, 3'd1, "T");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        sym_valid = 1'b1; sym_pattern = 5'b00000; sym_len = 3'd1;
        push_char(5'b00000, 3'd1);
        @(posedge clk);
        @(negedge clk);
        drain("b2b_first");
        push_char(5'b00000, 3'd1);
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        drain("b2b_second");
    endtask

    task automatic test_illegal;
        run_char(5'b10101, 3'd0, "len0");
        run_char(5'b10101, 3'd6, "len6");
        run_char(5'b01010, 3'd7, "len7");
    endtask

    task automatic test_reset_mid_mark;
        @(negedge clk);
        sym_valid = 1'b1; sym_pattern = 5'b00001; sym_len = 3'd2;
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        @(negedge clk);
        total++;
        if (key_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_mark key_out got=%0b exp=1", key_out);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({key_out, busy, sym_ready} !== 3'b001) begin
            bad++;
            $display("FAIL async_reset outputs got=%b exp=001", {key_out, busy, sym_ready});
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (char_done !== 1'b0 || key_out !== 1'b0) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=done%0b_key%0b exp=done0_key0", i, char_done, key_out);
            end
        end
    endtask

    initial begin
        test_reset;
        test_chars;
        test_back_to_back;
        test_illegal;
        test_reset_mid_mark;
        run_char(5'b00010, 3'd3, "after_reset_R");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
